load_store_unit: RTL

- Initiator side of the data-memory interface. Accepts one load/store request at a time from the core over a valid/ready handshake.
- Drives the word-addressed data memory (address, write data, write enable; combinational read data).
- Returns a response over a valid/ready handshake.
- Handles byte/halfword/word accesses: sub-word stores use read-modify-write, and loads are extracted and extended from the word read.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory load/store path: access sizes,
// controller states and the captured request control fields.
package mem_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WORD = 2'd1,
    WR_WORD = 2'd2,
    RESP    = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       is_unsigned;
  } req_ctrl_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering shared by both access paths: extracts and
// extends a load from the memory word, and merges a sub-word store into it.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic             sext;
  logic [LANES-1:0] byte_en;
  logic [31:0]      wdata_rep;

  assign lane_byte = rd[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? rd[31:16] : rd[15:0];
  assign sext      = ~is_unsigned;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_data = rd;
    case (size)
      SZ_BYTE: load_data = {{24{sext & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_data = {{16{sext & lane_half[15]}}, lane_half};
      default: load_data = rd;
    endcase
  end

  // Replicate the right-aligned store data into every lane, then let the
  // byte enables pick which lanes replace the word read from memory.
  always_comb begin
    byte_en   = '1;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        byte_en   = LANES'(1) << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        byte_en   = '1;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    store_word = rd;
    for (int i = 0; i < LANES; i++) begin
      store_word[8*i +: 8] = byte_en[i] ? wdata_rep[8*i +: 8] : rd[8*i +: 8];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-addressed data memory;
// sub-word stores are done as a read-modify-write of the containing word.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] WD,
  output logic              WE,
  input  logic [DATA_W-1:0] RD
);

  lsu_state_e        state_q, state_d;
  req_ctrl_t         ctrl_q, ctrl_d;
  logic [1:0]        lo_q, lo_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              misaligned;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  assign misaligned = (req_size == SZ_ILL)
                    | ((req_size == SZ_HALF) & req_addr[0])
                    | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

  lsu_lane_align u_align (
    .size        (ctrl_q.size),
    .addr_lo     (lo_q),
    .is_unsigned (ctrl_q.is_unsigned),
    .rd          (RD),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ctrl_d  = '{we: req_we, size: req_size, is_unsigned: req_unsigned};
          lo_d    = req_addr[1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = misaligned;
          if (misaligned) begin
            // Rejected requests never touch the memory port, A included.
            state_d = RESP;
          end else begin
            a_d = {2'b00, req_addr[ADDR_W-1:2]};
            if (req_we && (req_size == SZ_WORD)) begin
              wd_d    = req_wdata;
              state_d = WR_WORD;
            end else begin
              state_d = RD_WORD;
            end
          end
        end
      end

      RD_WORD: begin
        if (ctrl_q.we) begin
          wd_d    = store_word;
          state_d = WR_WORD;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end

      WR_WORD: state_d = RESP;

      RESP: begin
        if (resp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
      a_q     <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      lo_q    <= lo_d;
      wdata_q <= wdata_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // WE decodes straight from the state so an asynchronous reset drops it at once.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign WE         = (state_q == WR_WORD);
  assign A          = a_q;
  assign WD         = wd_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
